laser_scandoubler: RTL and testbench

Parametrised line-doubling scandoubler between the VTL video generator and the OSD. It converts 15 kHz video (active-low syncs, COLOR_W-bit RGB) into 31 kHz VGA by storing each input line and replaying it twice at double pixel rate. It also provides optional scanline dimming, a bypass mode and automatic line-length measurement.

---
 rtl/laser_video_pkg.sv | 34 +++
 rtl/laser_line_buffer.sv | 30 +++
 rtl/laser_scandoubler.sv | 235 +++++++++++++++++++++++
 tb/tb_laser_scandoubler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_video_pkg.sv
// Shared video types and helpers for the laser scandoubler.
// Holds the scanline mode encoding, the dim() helper and the default colour depth.
package laser_video_pkg;

  localparam int COLOR_W_DEF = 6;

  // Working width of dim(); callers zero-extend into it and truncate back.
  localparam int DIM_W = 16;

  typedef enum logic [1:0] {
    SL_OFF = 2'd0,
    SL_25  = 2'd1,
    SL_50  = 2'd2,
    SL_75  = 2'd3
  } sl_mode_e;

  // Control bits that travel alongside the RAM read, one stage ahead of the pins
  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic blank;
  } pix_ctl_t;

  // Scanline attenuation; every result is <= c, so no overflow is possible
  function automatic logic [DIM_W-1:0] dim(input logic [DIM_W-1:0] c, input sl_mode_e mode);
    case (mode)
      SL_25:   dim = c - (c >> 2);
      SL_50:   dim = c >> 1;
      SL_75:   dim = c >> 2;
      default: dim = c;
    endcase
  endfunction

endpackage

// File: rtl/laser_line_buffer.sv
// Two-bank line store: one write port and one registered read port.
// The bank select is the address MSB, so each bank spans 2**AW words.
module laser_line_buffer #(
  parameter int DW = 18,
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW:0]   waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW:0]   raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(2**(AW+1))-1];
  logic [DW-1:0] rdata_q;

  // Write port: the input side stores one pixel per enabled pix_ce
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port: one clock of latency, which the control pipe matches
  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/laser_scandoubler.sv
// 15 kHz -> 31 kHz line doubler: stores each input line, then replays it twice
// at clk_sys rate during the following input line.
// Optional feature macro: SCANDOUBLER_SCANLINES_EN (dims the second replay).
// Without it the scanlines port is accepted but ignored.
module laser_scandoubler
  import laser_video_pkg::*;
#(
  parameter int  COLOR_W  = COLOR_W_DEF,
  parameter int  LINE_MAX = 1024,
  localparam int AW       = $clog2(LINE_MAX)
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               pix_ce,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
  input  logic [1:0]         scanlines,
  input  logic               bypass,
  output logic               hs_out,
  output logic               vs_out,
  output logic [COLOR_W-1:0] r_out,
  output logic [COLOR_W-1:0] g_out,
  output logic [COLOR_W-1:0] b_out,
  output logic [AW:0]        line_len
);

  localparam logic [AW:0] LMAX = (AW+1)'(LINE_MAX);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  // ---------------- input side ----------------
  logic          hs_prev_q;
  logic          ils, hs_rise;
  logic [AW:0]   in_x_q, in_x_d;
  logic [AW:0]   line_len_q, line_len_d;
  logic [AW:0]   hs_cnt_q, hs_cnt_d;
  logic [AW:0]   hs_width_q, hs_width_d;
  logic          wbank_q, wbank_d;
  logic          vs_src_q, vs_src_d;

  assign ils     = pix_ce & hs_prev_q & ~hs_in;
  assign hs_rise = pix_ce & ~hs_prev_q & hs_in;

  // Input line bookkeeping: pixel index, measured length, bank swap, hsync width
  always_comb begin
    in_x_d     = in_x_q;
    line_len_d = line_len_q;
    hs_cnt_d   = hs_cnt_q;
    hs_width_d = hs_width_q;
    wbank_d    = wbank_q;
    vs_src_d   = vs_src_q;
    if (pix_ce) begin
      if (ils) begin
        in_x_d     = '0;
        wbank_d    = ~wbank_q;
        vs_src_d   = vs_in;
        line_len_d = (in_x_q >= LMAX) ? LMAX : in_x_q + ONE;
      end else if (in_x_q != LMAX) begin
        in_x_d = in_x_q + ONE;
      end
      if (!hs_in) begin
        if (hs_prev_q)          hs_cnt_d = ONE;
        else if (hs_cnt_q != '1) hs_cnt_d = hs_cnt_q + ONE;
      end
      // Clamp keeps hsync from swallowing a whole replay on short lines
      if (hs_rise) begin
        if (line_len_q == '0)                hs_width_d = '0;
        else if (hs_cnt_q > line_len_q - ONE) hs_width_d = line_len_q - ONE;
        else                                  hs_width_d = hs_cnt_q;
      end
    end
  end

  // Input side state registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev_q  <= 1'b0;
      in_x_q     <= '0;
      line_len_q <= '0;
      hs_cnt_q   <= '0;
      hs_width_q <= '0;
      wbank_q    <= 1'b0;
      vs_src_q   <= 1'b1;
    end else begin
      if (pix_ce) hs_prev_q <= hs_in;
      in_x_q     <= in_x_d;
      line_len_q <= line_len_d;
      hs_cnt_q   <= hs_cnt_d;
      hs_width_q <= hs_width_d;
      wbank_q    <= wbank_d;
      vs_src_q   <= vs_src_d;
    end
  end

  // ---------------- line store ----------------
  logic                         we;
  logic [AW:0]                  waddr, raddr;
  logic [2:0][COLOR_W-1:0]      wdata, rdata;

  assign we    = pix_ce & (in_x_q < LMAX);
  assign waddr = {wbank_q, in_x_q[AW-1:0]};
  assign wdata = {r_in, g_in, b_in};

  laser_line_buffer #(
    .DW (3*COLOR_W),
    .AW (AW)
  ) u_buf (
    .clk_i   (clk_sys),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // ---------------- output side ----------------
  logic [AW-1:0] out_x_q, out_x_d;
  logic          phase_q, phase_d;
  logic          out_wrap;
  pix_ctl_t      st1_q, st1_d;

  // Line length 0 gives all-ones here, which out_x (MSB clear) never matches
  assign out_wrap = ({1'b0, out_x_q} == line_len_q - ONE);
  assign raddr    = {~wbank_q, out_x_q};

  // Replay counter: ILS restarts phase 0, the wrap starts the second replay
  always_comb begin
    out_x_d = out_x_q + 1'b1;
    phase_d = phase_q;
    if (ils) begin
      out_x_d = '0;
      phase_d = 1'b0;
    end else if (out_wrap) begin
      out_x_d = '0;
      phase_d = ~phase_q;
    end
  end

  // Control for the pixel currently being read, aligned with RAM latency
  always_comb begin
    st1_d.hs_n  = ({1'b0, out_x_q} >= hs_width_q);
    st1_d.vs_n  = vs_src_q;
    st1_d.blank = ~st1_d.hs_n | (line_len_q == '0);
  end

  // Replay position and stage-1 control registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      out_x_q <= '0;
      phase_q <= 1'b0;
      st1_q   <= '{hs_n: 1'b1, vs_n: 1'b1, blank: 1'b1};
    end else begin
      out_x_q <= out_x_d;
      phase_q <= phase_d;
      st1_q   <= st1_d;
    end
  end

`ifdef SCANDOUBLER_SCANLINES_EN
  sl_mode_e mode_q, mode_d;
  logic     dim_p_q;
  sl_mode_e mode_p_q;

  // Mode only changes at an output line start so a line is never half-dimmed
  always_comb begin
    mode_d = mode_q;
    if (ils || out_wrap) mode_d = sl_mode_e'(scanlines);
  end

  // Mode register plus its copy aligned with the RAM read
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= SL_OFF;
      dim_p_q  <= 1'b0;
      mode_p_q <= SL_OFF;
    end else begin
      mode_q   <= mode_d;
      dim_p_q  <= phase_q & (mode_q != SL_OFF);
      mode_p_q <= mode_q;
    end
  end
`else
  logic unused_scanlines;
  assign unused_scanlines = ^scanlines;
`endif

  // ---------------- output stage ----------------
  logic [2:0][COLOR_W-1:0] pix, rgb_d;
  logic                    hs_d, vs_d;

  // Colour after optional dimming and blanking
  always_comb begin
    pix = rdata;
    for (int ch = 0; ch < 3; ch++) begin
`ifdef SCANDOUBLER_SCANLINES_EN
      if (dim_p_q) pix[ch] = COLOR_W'(dim(DIM_W'(rdata[ch]), mode_p_q));
`endif
      if (st1_q.blank) pix[ch] = '0;
    end
  end

  // Bypass bypasses only the pins; the doubler keeps tracking lines
  always_comb begin
    hs_d  = st1_q.hs_n;
    vs_d  = st1_q.vs_n;
    rgb_d = pix;
    if (bypass) begin
      hs_d  = hs_in;
      vs_d  = vs_in;
      rgb_d = {r_in, g_in, b_in};
    end
  end

  // Output pin registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_out <= 1'b1;
      vs_out <= 1'b1;
      r_out  <= '0;
      g_out  <= '0;
      b_out  <= '0;
    end else begin
      hs_out <= hs_d;
      vs_out <= vs_d;
      r_out  <= rgb_d[2];
      g_out  <= rgb_d[1];
      b_out  <= rgb_d[0];
    end
  end

  assign line_len = line_len_q;

endmodule

// File: tb/tb_laser_scandoubler.sv
// Directed bench for laser_scandoubler: scenario table for line doubling,
// scanlines and overlong lines, plus hand sequences for reset, vsync,
// bypass and mid-line reset.
module tb_laser_scandoubler;

  localparam int CW   = 6;
  localparam int LM   = 1024;
  localparam int NCAP = 4400;

`ifdef SCANDOUBLER_SCANLINES_EN
  localparam logic [CW-1:0] P1_M1 = 6'h2D;
  localparam logic [CW-1:0] P1_M2 = 6'h1E;
  localparam logic [CW-1:0] P1_M3 = 6'h0F;
`else
  localparam logic [CW-1:0] P1_M1 = 6'h3C;
  localparam logic [CW-1:0] P1_M2 = 6'h3C;
  localparam logic [CW-1:0] P1_M3 = 6'h3C;
`endif

  typedef struct {
    int            len;
    int            hsw;
    bit            ramp;
    logic [CW-1:0] cval;
    logic [1:0]    scan;
    int            exp_len;
    logic [CW-1:0] exp_p1;
  } vec_t;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          pix_ce = 1'b0, hs_in = 1'b1, vs_in = 1'b1, bypass = 1'b0;
  logic [1:0]    scanlines = 2'd0;
  logic [CW-1:0] r_in = '0, g_in = '0, b_in = '0;
  logic          hs_out, vs_out;
  logic [CW-1:0] r_out, g_out, b_out;
  logic [10:0]   line_len;

  laser_scandoubler #(.COLOR_W(CW), .LINE_MAX(LM)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .pix_ce    (pix_ce),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .r_in      (r_in),
    .g_in      (g_in),
    .b_in      (b_in),
    .scanlines (scanlines),
    .bypass    (bypass),
    .hs_out    (hs_out),
    .vs_out    (vs_out),
    .r_out     (r_out),
    .g_out     (g_out),
    .b_out     (b_out),
    .line_len  (line_len)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  logic          cap_hs [NCAP];
  logic [CW-1:0] cap_r [NCAP], cap_g [NCAP], cap_b [NCAP];
  int            cidx = 0;
  bit            cap_en = 1'b0;
  logic          vs_log [2048];
  int            gidx = 0;
  int            ils_at [8];
  int            line_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (cap_en && cidx < NCAP) begin
      cap_hs[cidx] = hs_out;
      cap_r[cidx]  = r_out;
      cap_g[cidx]  = g_out;
      cap_b[cidx]  = b_out;
      cidx++;
    end
    if (gidx < 2048) vs_log[gidx] = vs_out;
    gidx++;
  endtask

  // Ramp pixel; pixels past LINE_MAX are inverted so a stray write is visible
  function automatic logic [CW-1:0] pv(input int j, input int s);
    logic [CW-1:0] v;
    v = CW'(j + s);
    return (j > LM) ? ~v : v;
  endfunction

  task automatic run_line(input int len, input int hsw, input bit vsv, input int seed,
                          input int npix, input bit ramp, input logic [CW-1:0] cval);
    for (int j = 0; j < npix; j++) begin
      pix_ce = 1'b1;
      hs_in  = (j < hsw) ? 1'b0 : 1'b1;
      vs_in  = vsv;
      r_in   = ramp ? pv(j, seed) : cval;
      g_in   = ramp ? (r_in ^ 6'h15) : cval;
      b_in   = ramp ? (r_in ^ 6'h2A) : cval;
      if (j == 0 && line_no < 8) ils_at[line_no] = gidx;
      tick();
      pix_ce = 1'b0;
      tick();
    end
    line_no++;
  endtask

  vec_t          tbl [5];
  int            L, a, hl0, hl1, bad0, bad1, fb0, fb1, sA, sB, sC, sD, fl, ll, lcnt;
  logic [CW-1:0] e;
  logic          eh, mism;

  initial begin
    tbl[0] = '{912,  64, 1'b1, 6'h00, 2'd0, 912,  6'h00};
    tbl[1] = '{912,  64, 1'b0, 6'h3C, 2'd2, 912,  P1_M2};
    tbl[2] = '{912,  64, 1'b0, 6'h3C, 2'd3, 912,  P1_M3};
    tbl[3] = '{1100, 64, 1'b1, 6'h00, 2'd0, 1024, 6'h00};
    tbl[4] = '{600,  40, 1'b0, 6'h3C, 2'd1, 600,  P1_M1};

    // Reset held with live input
    reset_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pix_ce = i[0];
      hs_in  = ((i % 4) < 2);
      r_in = 6'h3F; g_in = 6'h3F; b_in = 6'h3F;
      tick();
      if (i == 3 || i == 9)
        check($sformatf("reset outs @%0d", i), {hs_out, vs_out, r_out, g_out, b_out, line_len},
              {1'b1, 1'b1, 18'h0, 11'h0});
    end
    reset_n = 1'b1;

    // Before the first ILS the output stays black with hsync high
    bad0 = 0;
    for (int i = 0; i < 50; i++) begin
      pix_ce = 1'b1; hs_in = 1'b1;
      tick();
      if (!(hs_out === 1'b1 && vs_out === 1'b1 && {r_out, g_out, b_out} === 18'h0)) bad0++;
      pix_ce = 1'b0;
      tick();
      if (!(hs_out === 1'b1 && vs_out === 1'b1 && {r_out, g_out, b_out} === 18'h0)) bad0++;
    end
    check("post-reset blank samples", bad0, 0);
    check("post-reset line_len", line_len, 0);

    // Scenario table: lines A, B, C, D; replay of B is captured during C (and 2 clk of D)
    for (int t = 0; t < 5; t++) begin
      scanlines = tbl[t].scan;
      sA = t * 16 + 1; sB = t * 16 + 5; sC = t * 16 + 9; sD = t * 16 + 13;
      run_line(tbl[t].len, tbl[t].hsw, 1'b1, sA, tbl[t].len, tbl[t].ramp, tbl[t].cval);
      run_line(tbl[t].len, tbl[t].hsw, 1'b1, sB, tbl[t].len, tbl[t].ramp, tbl[t].cval);
      cidx = 0; cap_en = 1'b1;
      run_line(tbl[t].len, tbl[t].hsw, 1'b1, sC, tbl[t].len, tbl[t].ramp, tbl[t].cval);
      check($sformatf("v%0d line_len", t), line_len, tbl[t].exp_len);
      run_line(tbl[t].len, tbl[t].hsw, 1'b1, sD, tbl[t].len, tbl[t].ramp, tbl[t].cval);
      cap_en = 1'b0;

      L = tbl[t].exp_len;
      hl0 = 0; hl1 = 0; bad0 = 0; bad1 = 0; fb0 = -1; fb1 = -1;
      for (int k = 2; k <= 2 * L + 1; k++) begin
        a  = (k - 2) % L;
        eh = (a >= tbl[t].hsw);
        if (!eh) e = '0;
        else if (tbl[t].ramp) e = (a + 1 < tbl[t].len) ? pv(a + 1, sB) : pv(0, sC);
        else e = (k - 2 >= L) ? tbl[t].exp_p1 : tbl[t].cval;
        if (tbl[t].ramp && eh)
          mism = (cap_hs[k] !== eh) || (cap_r[k] !== e) || (cap_g[k] !== (e ^ 6'h15)) ||
                 (cap_b[k] !== (e ^ 6'h2A));
        else
          mism = (cap_hs[k] !== eh) || (cap_r[k] !== e) || (cap_g[k] !== e) || (cap_b[k] !== e);
        if (k - 2 < L) begin
          if (cap_hs[k] === 1'b0) hl0++;
          if (mism) begin bad0++; if (fb0 < 0) fb0 = k; end
        end else begin
          if (cap_hs[k] === 1'b0) hl1++;
          if (mism) begin bad1++; if (fb1 < 0) fb1 = k; end
        end
      end
      check($sformatf("v%0d hs low clk replay0", t), hl0, tbl[t].hsw);
      check($sformatf("v%0d hs low clk replay1", t), hl1, tbl[t].hsw);
      check($sformatf("v%0d hs fall at ILS+2", t), {cap_hs[1], cap_hs[2]}, 2'b10);
      check($sformatf("v%0d hs fall at wrap+2", t), {cap_hs[L+1], cap_hs[L+2]}, 2'b10);
      check($sformatf("v%0d replay0 bad samples (first k=%0d)", t, fb0), bad0, 0);
      check($sformatf("v%0d replay1 bad samples (first k=%0d)", t, fb1), bad1, 0);
    end

    // Vsync: three low input lines give six low output lines, edges at ILS+2
    scanlines = 2'd0;
    gidx = 0; line_no = 0;
    for (int n = 0; n < 7; n++)
      run_line(100, 10, (n >= 2 && n <= 4) ? 1'b0 : 1'b1, 0, 100, 1'b0, 6'h15);
    fl = -1; ll = -1; lcnt = 0;
    for (int i = 0; i < gidx && i < 2048; i++) begin
      if (vs_log[i] !== 1'b1) begin
        lcnt++;
        if (fl < 0) fl = i;
        ll = i;
      end
    end
    check("vs_out fall index", fl, ils_at[2] + 2);
    check("vs_out rise index", ll + 1, ils_at[5] + 2);
    check("vs_out low clocks", lcnt, 600);

    // Bypass: pins follow the inputs one clock later
    bypass = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pix_ce = i[0];
      hs_in  = 1'($urandom);
      vs_in  = 1'($urandom);
      r_in   = CW'($urandom);
      g_in   = CW'($urandom);
      b_in   = CW'($urandom);
      tick();
      check($sformatf("bypass cycle %0d", i), {hs_out, vs_out, r_out, g_out, b_out},
            {hs_in, vs_in, r_in, g_in, b_in});
    end
    bypass = 1'b0;

    // Mid-line reset around out_x = 400
    pix_ce = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
    tick();
    pix_ce = 1'b0;
    tick();
    run_line(912, 64, 1'b1, 3, 912, 1'b1, 6'h00);
    run_line(912, 64, 1'b1, 7, 200, 1'b1, 6'h00);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid-line reset immediate", {hs_out, vs_out, r_out, g_out, b_out, line_len},
          {1'b1, 1'b1, 18'h0, 11'h0});
    pix_ce = 1'b1;
    tick();
    check("mid-line reset held", {hs_out, vs_out, r_out, g_out, b_out, line_len},
          {1'b1, 1'b1, 18'h0, 11'h0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
